// File: rtl/lightsaber_blade_driver.sv
// Blade length animator: walks the visible length between 0.00 and a
// latched target one hundredth at a time, every STEP_DIV clocks.
// Request semantics: ignite/retract are single-cycle strobes sampled on the
// rising edge. When both are high in the same cycle, retract wins and ignite
// is dropped entirely. There is no back-pressure; a request the current state
// does not use is ignored. The FSM state is held in the typed signal `state`
// so checkers can bind to it directly.
module lightsaber_blade_driver #(
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] len_int,
  input  logic [6:0] len_dec,
  input  logic       ignite,
  input  logic       retract,
  output logic [1:0] cur_int,
  output logic [6:0] cur_dec,
  output logic       blade_on,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_OFF, S_EXTENDING, S_ON, S_RETRACTING} state_t;

  localparam logic [7:0] PRE_MAX = 8'(STEP_DIV - 1);

  state_t     state, state_nx;
  logic [7:0] pre, pre_nx;
  logic [1:0] tgt_int, tgt_int_nx;
  logic [6:0] tgt_dec, tgt_dec_nx;
  // When set, RETRACTING stops at the target instead of at 0.00.
  logic       to_tgt, to_tgt_nx;
  logic [1:0] cur_int_nx;
  logic [6:0] cur_dec_nx;
  logic       done_nx;

  logic [6:0] in_dec;
  logic [8:0] in_val, cur_val, tgt_val, floor_val;
  logic       wrap, ign_acc, eff_to_tgt;
  logic [7:0] pre_inc;

  // Length as a single number of hundredths (0..399).
  function automatic logic [8:0] len_val(input logic [1:0] i, input logic [6:0] d);
    return 9'(i) * 9'd100 + 9'(d);
  endfunction

  assign in_dec     = (len_dec > 7'd99) ? 7'd99 : len_dec;
  assign in_val     = len_val(len_int, in_dec);
  assign cur_val    = len_val(cur_int, cur_dec);
  assign tgt_val    = len_val(tgt_int, tgt_dec);
  assign wrap       = (pre == PRE_MAX);
  assign pre_inc    = wrap ? 8'd0 : pre + 8'd1;
  assign ign_acc    = ignite & ~retract;
  // A retract while retracting to a target widens the run down to 0.00.
  assign eff_to_tgt = to_tgt & ~retract;
  assign floor_val  = eff_to_tgt ? tgt_val : 9'd0;

  // Next-state, next-length and done pulse.
  always_comb begin
    state_nx   = state;
    pre_nx     = pre;
    tgt_int_nx = tgt_int;
    tgt_dec_nx = tgt_dec;
    to_tgt_nx  = to_tgt;
    cur_int_nx = cur_int;
    cur_dec_nx = cur_dec;
    done_nx    = 1'b0;
    unique case (state)
      S_OFF: begin
        if (ign_acc) begin
          tgt_int_nx = len_int;
          tgt_dec_nx = in_dec;
          to_tgt_nx  = 1'b0;
          pre_nx     = 8'd0;
          if (in_val == 9'd0) begin
            state_nx = S_ON;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_EXTENDING;
          end
        end
      end
      S_EXTENDING: begin
        if (retract) begin
          state_nx  = S_RETRACTING;
          to_tgt_nx = 1'b0;
          pre_nx    = 8'd0;
        end else begin
          pre_nx = pre_inc;
          if (wrap) begin
            if (cur_dec == 7'd99) begin
              cur_dec_nx = 7'd0;
              cur_int_nx = cur_int + 2'd1;
            end else begin
              cur_dec_nx = cur_dec + 7'd1;
            end
            if (cur_val + 9'd1 == tgt_val) begin
              state_nx = S_ON;
              done_nx  = 1'b1;
            end
          end
        end
      end
      S_ON: begin
        if (retract) begin
          state_nx  = S_RETRACTING;
          to_tgt_nx = 1'b0;
          pre_nx    = 8'd0;
        end else if (ign_acc) begin
          tgt_int_nx = len_int;
          tgt_dec_nx = in_dec;
          pre_nx     = 8'd0;
          to_tgt_nx  = (in_val < cur_val);
          if (in_val > cur_val)      state_nx = S_EXTENDING;
          else if (in_val < cur_val) state_nx = S_RETRACTING;
        end
      end
      S_RETRACTING: begin
        if (ign_acc) begin
          tgt_int_nx = len_int;
          tgt_dec_nx = in_dec;
          pre_nx     = 8'd0;
          to_tgt_nx  = (in_val < cur_val);
          if (in_val > cur_val)      state_nx = S_EXTENDING;
          else if (in_val < cur_val) state_nx = S_RETRACTING;
          else                       state_nx = S_ON;
        end else begin
          to_tgt_nx = eff_to_tgt;
          pre_nx    = pre_inc;
          if (wrap) begin
            // Already at the floor (e.g. retract from ON at 0.00): finish in place.
            if (cur_val != floor_val) begin
              if (cur_dec == 7'd0) begin
                cur_dec_nx = 7'd99;
                cur_int_nx = cur_int - 2'd1;
              end else begin
                cur_dec_nx = cur_dec - 7'd1;
              end
            end
            if (cur_val == floor_val || cur_val - 9'd1 == floor_val) begin
              state_nx = (eff_to_tgt && tgt_val != 9'd0) ? S_ON : S_OFF;
              done_nx  = 1'b1;
            end
          end
        end
      end
      default: state_nx = S_OFF;
    endcase
  end

  // State, length and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      pre      <= 8'd0;
      tgt_int  <= 2'd0;
      tgt_dec  <= 7'd0;
      to_tgt   <= 1'b0;
      cur_int  <= 2'd0;
      cur_dec  <= 7'd0;
      blade_on <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      pre      <= pre_nx;
      tgt_int  <= tgt_int_nx;
      tgt_dec  <= tgt_dec_nx;
      to_tgt   <= to_tgt_nx;
      cur_int  <= cur_int_nx;
      cur_dec  <= cur_dec_nx;
      blade_on <= (state_nx == S_ON);
      busy     <= (state_nx == S_EXTENDING) || (state_nx == S_RETRACTING);
      done     <= done_nx;
    end
  end

endmodule

// File: doc/lightsaber_blade_driver.md
Name: lightsaber_blade_driver

Overview:
- Reads the stored lightsaber length: integer metres 0..3 plus hundredths 0..99.
- Animates the visible blade length from 0 up to that target on ignite, and back down to 0 on retract, one 0.01 m step per tick.
- Sits downstream of the length registers and feeds the blade display/LED logic.

Parameters:
- STEP_DIV, default 4: clock cycles per 0.01 m step. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- len_int  input  2  stored target length, integer metres (0..3).
- len_dec  input  7  stored target length, hundredths (0..99). Values 100..127 are clamped to 99.
- ignite  input  1  single-cycle request to extend the blade.
- retract  input  1  single-cycle request to retract the blade.
- cur_int  output  2  current blade length, integer part.
- cur_dec  output  7  current blade length, hundredths (always 0..99).
- blade_on  output  1  high in the ON state only.
- busy  output  1  high in the EXTENDING or RETRACTING state.
- done  output  1  one-cycle pulse when an extend or retract completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = OFF.
  - cur_int = 0, cur_dec = 0.
  - Target and prescaler cleared.
  - blade_on, busy and done all 0.
  - Reset mid-animation aborts the animation immediately; no done pulse.
- Target latch:
  - On an accepted ignite, tgt_int and tgt_dec are latched from len_int and len_dec (clamped).
  - The target is held until the next accepted ignite.
  - Changes to len_* at other times have no effect.
- Length arithmetic:
  - Lengths are compared as a 9-bit value, int*100 + dec, range 0..399.
  - Step up: dec 99 -> 0 with int+1.
  - Step down: dec 0 -> 99 with int-1.
  - Never steps above the target or below 0.00.
- Prescaler:
  - Counts 0..STEP_DIV-1 while in EXTENDING or RETRACTING.
  - A step occurs on the cycle the count wraps.
  - Cleared on every state entry, so the first step comes exactly STEP_DIV cycles after entry.
- States:
  - OFF:
    - ignite -> EXTENDING, target latched.
    - If the latched target is 0.00, go to ON instead with done pulsed on the transition cycle.
    - retract is ignored.
  - EXTENDING:
    - Each step adds 0.01.
    - When the step makes cur equal to target -> ON, with done high in that same cycle the final value appears.
    - retract -> RETRACTING from the current value; no done pulse.
    - ignite is ignored.
  - ON:
    - cur holds the target.
    - retract -> RETRACTING.
    - ignite re-latches the target:
      - new target > cur -> EXTENDING;
      - new target < cur -> RETRACTING-TO-TARGET, which is RETRACTING with floor = new target;
      - equal -> stay ON, no done pulse.
  - RETRACTING:
    - Each step subtracts 0.01.
    - Reaching floor 0.00 -> OFF with done.
    - Reaching a nonzero floor -> ON with done.
    - ignite -> re-latch the target, go to EXTENDING (or per the comparison rule above).
- Simultaneous ignite and retract in the same cycle: retract wins. ignite is discarded entirely and the target is not re-latched.
- Outputs are registered; blade_on and busy reflect the state after the clock edge.
- Step timing: an extend to target T takes exactly (T*100)*STEP_DIV cycles from the ignite edge to done.

Test Plan:
1. Reset and basic extend:
   - Stimulus: rst_n low, then high; len = 1.05, STEP_DIV = 4; ignite at cycle 10.
   - Required: busy = 1 from cycle 11; cur reaches 1.05 after 105 steps (420 cycles); done = 1 exactly once; blade_on = 1.
2. Decimal wrap:
   - Stimulus: target 2.00.
   - Required: cur passes 0.99 -> 1.00 and 1.99 -> 2.00 with no 1.100 value. On retract, cur passes 1.00 -> 0.99 and ends at 0.00 with done; state OFF.
3. Abort and reversal:
   - Stimulus: extend to 3.99; retract at cur = 0.50.
   - Required: no done pulse; cur steps 0.49, 0.48, ... down to 0.00, then done; blade_on stays 0 throughout.
4. Clamp and zero target:
   - Stimulus: len_dec = 120, len_int = 0, then ignite.
   - Required: target is 0.99, run completes at 0.99.
   - Stimulus: len = 0.00, ignite from OFF.
   - Required: ON with done on the next cycle and cur = 0.00.
5. Simultaneous requests and re-target:
   - Stimulus: ignite and retract together while ON at 1.00.
   - Required: RETRACTING; the target is not re-latched.
   - Stimulus: while ON at 1.00, set len = 0.50 and ignite.
   - Required: cur retracts to 0.50, then ON with done.
6. Asynchronous reset mid-run:
   - Stimulus: drop rst_n between clock edges during EXTENDING at 0.30.
   - Required: outputs go to 0 immediately without waiting for clk, and there is no done pulse. After release, ignite restarts from 0.00.
